// File: rtl/qspi_pkg.sv
// Shared opcodes, responder state encoding and sizing for the QSPI flash responder.
package qspi_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CNT_W  = 6;

    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_READ4  = 8'h13;
    localparam logic [7:0] OP_QREAD  = 8'hEB;
    localparam logic [7:0] OP_QREAD4 = 8'hEC;
    localparam logic [7:0] OP_EN4B   = 8'hB7;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        IGNORE
    } resp_state_e;

    // Index of the final address beat: nibbles in quad mode, bits in single mode.
    function automatic logic [CNT_W-1:0] addr_last_beat(input logic quad, input logic wide);
        if (quad) begin
            return wide ? CNT_W'(7) : CNT_W'(5);
        end
        return wide ? CNT_W'(31) : CNT_W'(23);
    endfunction

endpackage

// File: rtl/qspi_flash_responder_if.sv
// QSPI pad bundle between a flash controller (master) and the responder (slave).
interface qspi_flash_responder_if;

    logic       cs_n_in;
    logic       sclk_in;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic [3:0] io_oe;

    modport master (
        output cs_n_in,
        output sclk_in,
        output io_in,
        input  io_out,
        input  io_oe
    );

    modport slave (
        input  cs_n_in,
        input  sclk_in,
        input  io_in,
        output io_out,
        output io_oe
    );

endinterface

// File: rtl/qspi_resp_sync.sv
// Brings cs_n and sclk into the h_clk domain and derives edge pulses.
module qspi_resp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n_in,
    input  logic sclk_in,
    output logic cs_n_sync,
    output logic cs_fall_c,
    output logic sclk_rise_c,
    output logic sclk_fall_c
);

    logic cs_meta_q;
    logic cs_sync_q;
    logic cs_prev_q;
    logic sclk_meta_q;
    logic sclk_sync_q;
    logic sclk_prev_q;

    // Two-flop synchronizers plus one history flop each for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_meta_q   <= cs_n_in;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sclk_meta_q <= sclk_in;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
        end
    end

    assign cs_n_sync   = cs_sync_q;
    assign cs_fall_c   = cs_prev_q & ~cs_sync_q;
    assign sclk_rise_c = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall_c = ~sclk_sync_q & sclk_prev_q;

endmodule

// File: rtl/qspi_flash_responder.sv
// Behavioural QSPI flash: single/quad reads from a preloadable word array.
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 64,
    parameter int unsigned DUMMY_CYCLES = 6
) (
    input  logic                  h_clk,
    input  logic                  h_rstn,
    qspi_flash_responder_if.slave bus,
    input  logic                  mem_wr_en_in,
    input  logic [IDX_W-1:0]      mem_wr_addr_in,
    input  logic [WORD_W-1:0]     mem_wr_data_in,
    output logic                  addr4_mode_out,
    output logic                  busy_out,
    output logic                  cmd_err_out
);

    logic cs_n_sync;
    logic cs_fall_c;
    logic sclk_rise_c;
    logic sclk_fall_c;

    qspi_resp_sync u_sync (
        .clk         (h_clk),
        .rst_n       (h_rstn),
        .cs_n_in     (bus.cs_n_in),
        .sclk_in     (bus.sclk_in),
        .cs_n_sync   (cs_n_sync),
        .cs_fall_c   (cs_fall_c),
        .sclk_rise_c (sclk_rise_c),
        .sclk_fall_c (sclk_fall_c)
    );

    logic [WORD_W-1:0] mem_q [MEM_DEPTH];

    resp_state_e       state_q,   state_d;
    logic [WORD_W-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              quad_q,    quad_d;
    logic              wide_q,    wide_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [3:0]        io_out_q,  io_out_d;
    logic [3:0]        io_oe_q,   io_oe_d;
    logic              addr4_q,   addr4_d;
    logic              cmd_err_q, cmd_err_d;
    logic              busy_q,    busy_d;

    logic [7:0]        opcode_c;
    logic [WORD_W-1:0] addr_next_c;
    logic [WORD_W-1:0] word_c;
    logic [WORD_W-1:0] cur_c;
    logic              last_c;

    // Backdoor preload; blocked while a transaction is in flight, never reset.
    always_ff @(posedge h_clk) begin
        if (mem_wr_en_in && !busy_q) begin
            mem_q[mem_wr_addr_in] <= mem_wr_data_in;
        end
    end

    assign word_c = mem_q[idx_q];

    // Next-state and output decode, advanced only by synchronized sclk edges.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        quad_d      = quad_q;
        wide_d      = wide_q;
        idx_d       = idx_q;
        io_out_d    = io_out_q;
        io_oe_d     = io_oe_q;
        addr4_d     = addr4_q;
        cmd_err_d   = 1'b0;
        busy_d      = ~cs_n_sync;
        opcode_c    = {shift_q[6:0], bus.io_in[0]};
        addr_next_c = quad_q ? {shift_q[27:0], bus.io_in} : {shift_q[30:0], bus.io_in[0]};
        cur_c       = (cnt_q == '0) ? word_c : shift_q;
        last_c      = 1'b0;

        if (cs_n_sync) begin
            // Deselect abandons whatever was in progress and releases the pads.
            state_d  = IDLE;
            shift_d  = '0;
            cnt_d    = '0;
            quad_d   = 1'b0;
            wide_d   = 1'b0;
            io_out_d = 4'b0000;
            io_oe_d  = 4'b0000;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall_c) begin
                        state_d = CMD;
                        shift_d = '0;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise_c) begin
                        shift_d = {shift_q[30:0], bus.io_in[0]};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            shift_d = '0;
                            cnt_d   = '0;
                            case (opcode_c)
                                OP_READ: begin
                                    quad_d  = 1'b0;
                                    wide_d  = addr4_q;
                                    state_d = ADDR;
                                end
                                OP_READ4: begin
                                    quad_d  = 1'b0;
                                    wide_d  = 1'b1;
                                    state_d = ADDR;
                                end
                                OP_QREAD: begin
                                    quad_d  = 1'b1;
                                    wide_d  = addr4_q;
                                    state_d = ADDR;
                                end
                                OP_QREAD4: begin
                                    quad_d  = 1'b1;
                                    wide_d  = 1'b1;
                                    state_d = ADDR;
                                end
                                OP_EN4B: begin
                                    addr4_d = 1'b1;
                                    state_d = IGNORE;
                                end
                                default: begin
                                    cmd_err_d = 1'b1;
                                    state_d   = IGNORE;
                                end
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise_c) begin
                        shift_d = addr_next_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == addr_last_beat(quad_q, wide_q)) begin
                            cnt_d = '0;
                            idx_d = addr_next_c[7:2];
                            if (quad_q && (DUMMY_CYCLES != 0)) begin
                                state_d = DUMMY;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    end
                end
                DUMMY: begin
                    io_oe_d = 4'b0000;
                    if (sclk_rise_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    // A fresh word is fetched on the first fall of each word.
                    if (sclk_fall_c) begin
                        if (quad_q) begin
                            io_out_d = cur_c[31:28];
                            io_oe_d  = 4'b1111;
                            shift_d  = {cur_c[27:0], 4'b0000};
                            last_c   = (cnt_q == CNT_W'(7));
                        end else begin
                            io_out_d = {2'b00, cur_c[31], 1'b0};
                            io_oe_d  = 4'b0010;
                            shift_d  = {cur_c[30:0], 1'b0};
                            last_c   = (cnt_q == CNT_W'(31));
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_c) begin
                            cnt_d = '0;
                            idx_d = (idx_q == IDX_W'(MEM_DEPTH - 1)) ? '0 : idx_q + IDX_W'(1);
                        end
                    end
                end
                IGNORE: begin
                    io_oe_d = 4'b0000;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            quad_q    <= 1'b0;
            wide_q    <= 1'b0;
            idx_q     <= '0;
            io_out_q  <= 4'b0000;
            io_oe_q   <= 4'b0000;
            addr4_q   <= 1'b0;
            cmd_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            quad_q    <= quad_d;
            wide_q    <= wide_d;
            idx_q     <= idx_d;
            io_out_q  <= io_out_d;
            io_oe_q   <= io_oe_d;
            addr4_q   <= addr4_d;
            cmd_err_q <= cmd_err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.io_out     = io_out_q;
    assign bus.io_oe      = io_oe_q;
    assign addr4_mode_out = addr4_q;
    assign busy_out       = busy_q;
    assign cmd_err_out    = cmd_err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: a bit-banged controller against a word-level flash model.
module tb_qspi_flash_responder;
    import qspi_pkg::*;

    localparam int MEM_DEPTH = 64;
    localparam int DUMMY     = 6;
    localparam int HALF      = 5;

    logic        h_clk = 1'b0;
    logic        h_rstn;
    logic        mem_wr_en;
    logic [5:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        addr4_mode;
    logic        busy;
    logic        cmd_err;

    qspi_flash_responder_if bus ();

    qspi_flash_responder #(.MEM_DEPTH(MEM_DEPTH), .DUMMY_CYCLES(DUMMY)) dut (
        .h_clk          (h_clk),
        .h_rstn         (h_rstn),
        .bus            (bus),
        .mem_wr_en_in   (mem_wr_en),
        .mem_wr_addr_in (mem_wr_addr),
        .mem_wr_data_in (mem_wr_data),
        .addr4_mode_out (addr4_mode),
        .busy_out       (busy),
        .cmd_err_out    (cmd_err)
    );

    always #5 h_clk = ~h_clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [MEM_DEPTH];
    logic        model_a4 = 1'b0;
    logic [3:0]  cap_out [128];
    logic [3:0]  cap_oe  [128];
    int          err_cycles = 0;
    int          oe_cycles  = 0;

    // Running tallies of cmd_err high cycles and pad-driving cycles.
    always @(negedge h_clk) begin
        if (cmd_err === 1'b1) err_cycles++;
        if (bus.io_oe !== 4'b0000) oe_cycles++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // Expected pad value for data beat k of a read starting at addr.
    function automatic logic [3:0] exp_beat(input logic quad, input logic [31:0] addr, input int k);
        int          per;
        int          idx;
        int          pos;
        logic [31:0] w;
        per = quad ? 8 : 32;
        idx = (int'(addr[7:2]) + k / per) % MEM_DEPTH;
        pos = k % per;
        w   = model_mem[idx];
        if (quad) return w[31 - 4*pos -: 4];
        return {2'b00, w[31 - pos], 1'b0};
    endfunction

    task automatic backdoor(input int idx, input logic [31:0] d, input logic taken);
        @(negedge h_clk);
        mem_wr_en   = 1'b1;
        mem_wr_addr = 6'(idx);
        mem_wr_data = d;
        @(negedge h_clk);
        mem_wr_en   = 1'b0;
        if (taken) model_mem[idx] = d;
    endtask

    task automatic cs_assert();
        @(negedge h_clk);
        bus.cs_n_in = 1'b0;
        repeat (3) @(negedge h_clk);
    endtask

    task automatic cs_release();
        @(negedge h_clk);
        bus.cs_n_in = 1'b1;
        bus.sclk_in = 1'b0;
        repeat (6) @(negedge h_clk);
    endtask

    // One sclk period; pads are sampled just before the rising edge.
    task automatic beat(input logic [3:0] drive, output logic [3:0] got_out, output logic [3:0] got_oe);
        bus.io_in = drive;
        repeat (HALF) @(negedge h_clk);
        got_out = bus.io_out;
        got_oe  = bus.io_oe;
        bus.sclk_in = 1'b1;
        repeat (HALF) @(negedge h_clk);
        bus.sclk_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] op);
        logic [3:0] o, e;
        for (int i = 7; i >= 0; i--) beat({3'b000, op[i]}, o, e);
    endtask

    task automatic do_read(input logic [7:0] op, input logic [31:0] addr, input int n, output int dummy_drive);
        logic       quad, wide;
        logic [3:0] o, e;
        quad = (op == OP_QREAD) || (op == OP_QREAD4);
        wide = (op == OP_READ4) || (op == OP_QREAD4) || model_a4;
        dummy_drive = 0;
        cs_assert();
        send_byte(op);
        if (quad) begin
            for (int i = (wide ? 7 : 5); i >= 0; i--) beat(addr[4*i +: 4], o, e);
            for (int i = 0; i < DUMMY; i++) begin
                beat(4'b0000, o, e);
                if (e !== 4'b0000) dummy_drive++;
            end
        end else begin
            for (int i = (wide ? 31 : 23); i >= 0; i--) beat({3'b000, addr[i]}, o, e);
        end
        for (int k = 0; k < n; k++) beat(4'b0000, cap_out[k], cap_oe[k]);
    endtask

    task automatic test_reset();
        h_rstn = 1'b0;
        repeat (3) @(negedge h_clk);
        checks++;
        if (bus.io_oe !== 4'b0000 || bus.io_out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pads: io_oe=%b io_out=%b, required 0000/0000", bus.io_oe, bus.io_out);
        end
        checks++;
        if (addr4_mode !== 1'b0 || busy !== 1'b0 || cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: addr4=%b busy=%b err=%b, required 0/0/0", addr4_mode, busy, cmd_err);
        end
        h_rstn = 1'b1;
        repeat (4) @(negedge h_clk);
        checks++;
        if (busy !== 1'b0 || bus.io_oe !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%b io_oe=%b, required 0/0000", busy, bus.io_oe);
        end
    endtask

    task automatic test_single_read();
        logic [31:0] got;
        int          bad_oe, dd;
        backdoor(2, 32'hDEADBEEF, 1'b1);
        do_read(OP_READ, 32'h0000_0008, 32, dd);
        bad_oe = 0;
        for (int k = 0; k < 32; k++) begin
            got[31 - k] = cap_out[k][1];
            if (cap_oe[k] !== 4'b0010) bad_oe++;
        end
        checks++;
        if (got !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_word2: io1 word=%h, required deadbeef", got);
        end
        checks++;
        if (bad_oe != 0) begin
            failures++;
            $display("FAIL single_oe: %0d beats with io_oe!=0010, required 0", bad_oe);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_during: busy=%b, required 1", busy);
        end
        @(negedge h_clk);
        bus.cs_n_in = 1'b1;
        repeat (3) @(posedge h_clk);
        #1;
        checks++;
        if (bus.io_oe !== 4'b0000) begin
            failures++;
            $display("FAIL release_3clk: io_oe=%b three clocks after deselect, required 0000", bus.io_oe);
        end
        repeat (4) @(negedge h_clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_random_single();
        logic [7:0]  op;
        logic [31:0] addr;
        logic [3:0]  ex;
        int          n, dd;
        for (int t = 0; t < 4; t++) begin
            op   = ($urandom_range(0, 1) == 0) ? OP_READ : OP_READ4;
            addr = $urandom();
            n    = 32 + int'($urandom_range(0, 40));
            do_read(op, addr, n, dd);
            for (int k = 0; k < n; k++) begin
                ex = exp_beat(1'b0, addr, k);
                checks++;
                if ((cap_out[k] & 4'b0010) !== ex || cap_oe[k] !== 4'b0010) begin
                    failures++;
                    $display("FAIL rand_single op=%h addr=%h beat %0d: io_out=%b io_oe=%b, required io1 of %b oe 0010",
                             op, addr, k, cap_out[k], cap_oe[k], ex);
                end
            end
            cs_release();
        end
    endtask

    task automatic test_quad_wrap();
        logic [3:0] ex;
        int         dd;
        do_read(OP_QREAD, 32'h0000_00FC, 16, dd);
        checks++;
        if (dd != 0) begin
            failures++;
            $display("FAIL wrap_dummy_oe: %0d dummy beats driven, required 0", dd);
        end
        for (int k = 0; k < 16; k++) begin
            ex = exp_beat(1'b1, 32'h0000_00FC, k);
            checks++;
            if (cap_out[k] !== ex || cap_oe[k] !== 4'b1111) begin
                failures++;
                $display("FAIL quad_wrap beat %0d: io_out=%h io_oe=%b, required %h 1111", k, cap_out[k], cap_oe[k], ex);
            end
        end
        cs_release();
    endtask

    task automatic test_bad_opcode();
        int         e0, o0;
        logic [3:0] o, e;
        e0 = err_cycles;
        o0 = oe_cycles;
        cs_assert();
        send_byte(8'h9F);
        for (int i = 0; i < 8; i++) beat(4'($urandom()), o, e);
        checks++;
        if (err_cycles - e0 != 1) begin
            failures++;
            $display("FAIL bad_op_pulse: cmd_err high %0d cycles, required 1", err_cycles - e0);
        end
        checks++;
        if (oe_cycles - o0 != 0) begin
            failures++;
            $display("FAIL bad_op_oe: %0d cycles driving, required 0", oe_cycles - o0);
        end
        cs_release();
        checks++;
        if (addr4_mode !== 1'b0) begin
            failures++;
            $display("FAIL bad_op_addr4: addr4=%b, required 0", addr4_mode);
        end
    endtask

    task automatic test_abort();
        logic [3:0]  o, e, ex;
        logic [31:0] addr;
        int          dd;
        cs_assert();
        send_byte(OP_READ);
        for (int i = 0; i < 10; i++) beat({3'b000, 1'($urandom())}, o, e);
        cs_release();
        checks++;
        if (busy !== 1'b0 || bus.io_oe !== 4'b0000) begin
            failures++;
            $display("FAIL abort_idle: busy=%b io_oe=%b, required 0/0000", busy, bus.io_oe);
        end
        addr = {8'h00, 24'($urandom())};
        do_read(OP_READ, addr, 40, dd);
        for (int k = 0; k < 40; k++) begin
            ex = exp_beat(1'b0, addr, k);
            checks++;
            if ((cap_out[k] & 4'b0010) !== ex || cap_oe[k] !== 4'b0010) begin
                failures++;
                $display("FAIL after_abort addr=%h beat %0d: io_out=%b io_oe=%b, required io1 of %b",
                         addr, k, cap_out[k], cap_oe[k], ex);
            end
        end
        cs_release();
    endtask

    task automatic test_busy_write_block();
        logic [31:0] got;
        int          idx, dd;
        idx = int'($urandom_range(0, MEM_DEPTH - 1));
        cs_assert();
        send_byte(OP_READ);
        backdoor(idx, ~model_mem[idx], 1'b0);
        cs_release();
        do_read(OP_READ, 32'(idx * 4), 32, dd);
        for (int k = 0; k < 32; k++) got[31 - k] = cap_out[k][1];
        checks++;
        if (got !== model_mem[idx]) begin
            failures++;
            $display("FAIL busy_write_blocked word %0d: read %h, required %h", idx, got, model_mem[idx]);
        end
        cs_release();
    endtask

    task automatic test_addr4_quad();
        logic [3:0]  o, e, ex;
        logic [7:0]  op;
        logic [31:0] addr;
        int          e0, dd, n;
        e0 = err_cycles;
        cs_assert();
        send_byte(OP_EN4B);
        for (int i = 0; i < 4; i++) beat(4'b0000, o, e);
        cs_release();
        model_a4 = 1'b1;
        checks++;
        if (addr4_mode !== 1'b1 || err_cycles != e0) begin
            failures++;
            $display("FAIL en4b: addr4=%b err_cycles+%0d, required 1 and +0", addr4_mode, err_cycles - e0);
        end
        backdoor(1, 32'h12345678, 1'b1);
        do_read(OP_QREAD4, 32'h0000_0004, 8, dd);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap_out[k] !== 4'(k + 1) || cap_oe[k] !== 4'b1111) begin
                failures++;
                $display("FAIL ec_word1 beat %0d: io_out=%h io_oe=%b, required %h 1111", k, cap_out[k], cap_oe[k], 4'(k + 1));
            end
        end
        checks++;
        if (dd != 0 || addr4_mode !== 1'b1) begin
            failures++;
            $display("FAIL ec_state: dummy driven=%0d addr4=%b, required 0/1", dd, addr4_mode);
        end
        cs_release();
        for (int t = 0; t < 3; t++) begin
            op   = (t == 1) ? OP_READ : OP_QREAD;
            addr = $urandom();
            n    = (op == OP_READ) ? 40 : 8 + int'($urandom_range(0, 16));
            do_read(op, addr, n, dd);
            for (int k = 0; k < n; k++) begin
                ex = exp_beat(op == OP_QREAD, addr, k);
                checks++;
                if (op == OP_QREAD) begin
                    if (cap_out[k] !== ex || cap_oe[k] !== 4'b1111) begin
                        failures++;
                        $display("FAIL a4_quad addr=%h beat %0d: io_out=%h io_oe=%b, required %h 1111",
                                 addr, k, cap_out[k], cap_oe[k], ex);
                    end
                end else if ((cap_out[k] & 4'b0010) !== ex || cap_oe[k] !== 4'b0010) begin
                    failures++;
                    $display("FAIL a4_single addr=%h beat %0d: io_out=%b io_oe=%b, required io1 of %b",
                             addr, k, cap_out[k], cap_oe[k], ex);
                end
            end
            cs_release();
        end
    endtask

    task automatic test_reset_mid_data();
        logic [31:0] addr, got, ex;
        int          dd;
        do_read(OP_QREAD, $urandom(), 5, dd);
        checks++;
        if (bus.io_oe !== 4'b1111) begin
            failures++;
            $display("FAIL pre_reset_drive: io_oe=%b, required 1111", bus.io_oe);
        end
        @(negedge h_clk);
        h_rstn = 1'b0;
        #1;
        checks++;
        if (bus.io_oe !== 4'b0000 || addr4_mode !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_data: io_oe=%b addr4=%b busy=%b, required 0000/0/0", bus.io_oe, addr4_mode, busy);
        end
        model_a4    = 1'b0;
        bus.cs_n_in = 1'b1;
        bus.sclk_in = 1'b0;
        repeat (2) @(negedge h_clk);
        h_rstn = 1'b1;
        repeat (4) @(negedge h_clk);
        addr = {8'h00, 24'($urandom())};
        ex   = model_mem[addr[7:2]];
        do_read(OP_READ, addr, 32, dd);
        for (int k = 0; k < 32; k++) got[31 - k] = cap_out[k][1];
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL mem_kept_over_reset addr=%h: read %h, required %h", addr, got, ex);
        end
        cs_release();
    endtask

    initial begin
        bus.cs_n_in = 1'b1;
        bus.sclk_in = 1'b0;
        bus.io_in   = 4'b0000;
        mem_wr_en   = 1'b0;
        mem_wr_addr = 6'd0;
        mem_wr_data = 32'd0;
        test_reset();
        for (int i = 0; i < MEM_DEPTH; i++) backdoor(i, $urandom(), 1'b1);
        test_single_read();
        test_random_single();
        test_quad_wrap();
        test_bad_opcode();
        test_abort();
        test_busy_write_block();
        test_addr4_quad();
        test_reset_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qspi_flash_responder.md
QSPI_FLASH_RESPONDER -- requirements
Module: qspi_flash_responder

Interface
REQ-001 Parameter MEM_DEPTH, 64, number of 32-bit words in the internal array; the word index is addr[7:2].
REQ-002 Parameter DUMMY_CYCLES, 6, number of sclk cycles between the last address bit and the first data bit for quad reads.
REQ-003 Port h_clk  in  1  system clock; the only clock in the block.
REQ-004 Port h_rstn  in  1  asynchronous, active-low reset.
REQ-005 Port cs_n_in  in  1  flash chip select from the controller, active low.
REQ-006 Port sclk_in  in  1  serial clock from the controller; it is sampled as data and is not a clock.
REQ-007 Port io_in  in  4  values on the io3..io0 pads.
REQ-008 Port io_out  out  4  drive values for the io3..io0 pads.
REQ-009 Port io_oe  out  4  per-line output enable; 1 = drive.
REQ-010 Port mem_wr_en_in / mem_wr_addr_in / mem_wr_data_in  in  1/6/32  backdoor preload write port, ignored while busy_out=1.
REQ-011 Port addr4_mode_out  out  1  4-byte address mode flag.
REQ-012 Port busy_out  out  1  high while cs_n is asserted, as synchronized internally.
REQ-013 Port cmd_err_out  out  1  single-h_clk pulse on an unsupported opcode.

Function
REQ-014 cs_n_in and sclk_in SHALL pass through 2-flop synchronizers; rise/fall edge pulses SHALL be derived from the synchronized sclk.
REQ-015 h_clk SHALL run at least 8x the sclk frequency (controller clk_div >= 4); io_in SHALL be captured on each synchronized sclk rise.
REQ-016 Outputs SHALL update one h_clk after a synchronized sclk fall.
REQ-017 FSM states: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-018 IDLE -> CMD SHALL occur on a synchronized cs_n fall.
REQ-019 CMD SHALL shift 8 bits MSB-first from io_in[0] only.
REQ-020 Opcode 0x03: single-line read; address is 3 bytes, or 4 bytes when addr4_mode=1; goes to ADDR.
REQ-021 Opcode 0x13: single-line read; address is always 4 bytes.
REQ-022 Opcode 0xEB: quad read; address width follows addr4_mode.
REQ-023 Opcode 0xEC: quad read; address is always 4 bytes.
REQ-024 Opcode 0xB7: set addr4_mode=1 on the 8th bit, then go to IGNORE.
REQ-025 Any other opcode SHALL pulse cmd_err_out and go to IGNORE.
REQ-026 ADDR in single mode SHALL take 24 or 32 bits MSB-first on io_in[0].
REQ-027 ADDR in quad mode SHALL take 6 or 8 nibbles, {io3,io2,io1,io0} per rise.
REQ-028 After the last address rise, single reads SHALL go to DATA; quad reads SHALL go to DUMMY.
REQ-029 DUMMY SHALL count DUMMY_CYCLES rises with io_oe=0000, then go to DATA.
REQ-030 DATA in single mode SHALL drive the word MSB-first on io_out[1] with io_oe=0010, one bit per fall.
REQ-031 DATA in quad mode SHALL drive bits[31:28] first on io_out[3:0] with io_oe=1111, one nibble per fall.
REQ-032 The first data bit or nibble SHALL be driven on the fall that follows the last address rise (single) or the last dummy rise (quad).
REQ-033 After each full word the word index SHALL increment and wrap modulo MEM_DEPTH, so bursts continue until cs_n deasserts.
REQ-034 A cs_n rise in any state SHALL force IDLE and io_oe=0000 within 3 h_clk, and SHALL discard partial command, address and bit counters.
REQ-035 A backdoor write and a DATA-state read to the same word in the same cycle SHALL NOT occur, because backdoor writes are blocked while busy.
REQ-036 addr4_mode SHALL persist across transactions and be cleared only by reset.

Reset
REQ-037 On h_rstn=0, asynchronously: state=IDLE, io_out=0000, io_oe=0000, addr4_mode_out=0, busy_out=0, cmd_err_out=0, synchronizers set to cs_n=1 and sclk=0, all counters 0.
REQ-038 Memory contents SHALL NOT be reset.
REQ-039 Reset mid-transaction SHALL release the bus immediately.

Structure
REQ-040 qspi_pkg SHALL hold the opcode constants (0x03, 0x13, 0xEB, 0xEC, 0xB7) and the responder state enum.
REQ-041 Synchronizer and edge detect SHALL live in sub-module qspi_resp_sync.
REQ-042 The memory SHALL be an inferred register array in the top.

Verification
REQ-043 Preload word2=0xDEADBEEF; 0x03 with addr 0x000008 plus 32 clocks -> io1 serial 0xDEADBEEF MSB-first, io_oe=0010.
REQ-044 0xB7, then 0xEC with addr 0x00000004, 6 dummy, 8 clocks (word1=0x12345678) -> nibbles 1,2,3,4,5,6,7,8 on io3..0 and addr4_mode_out=1.
REQ-045 0xEB burst at addr 0xFC with MEM_DEPTH=64, 16 data clocks -> word63 then word0 (wrap).
REQ-046 Opcode 0x9F -> cmd_err_out pulses once, io_oe stays 0000 until cs_n rises.
REQ-047 cs_n rises after 10 address bits, then a new 0x03 -> correct data; no residue from the aborted transaction.
REQ-048 h_rstn low during DATA -> io_oe=0000 immediately and addr4_mode_out=0.
